mem_io_bridge: RTL and testbench
================================

Name: mem_io_bridge

Overview:
- Memory-stage address decoder that sits between the EX/MEM pipeline register and DataMemory, ahead of MEM/WB.
- Steers loads and stores in a 32-byte I/O window to on-block registers instead of RAM.
- Registers: output port, synchronized input port with change detect, interval timer, and a maskable interrupt line.
- Replaces the constant-zero PortOut with a software-driven port.

Parameters:
- IO_BASE, 32'h1001_0000, byte base of the I/O window; must be 32-byte aligned.
- IN_WIDTH, 8, width of PortIn.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock and one reset, no other reset.
- Address  in  32  byte address from EX/MEM ALU result.
- WriteData  in  32  store data from EX/MEM.
- MemWrite  in  1  store strobe from EX/MEM.
- MemRead  in  1  load strobe from EX/MEM.
- RAMReadData  in  32  DataMemory read data.
- PortIn  in  IN_WIDTH  asynchronous external input.
- RAM_MemWrite  out  1  gated store strobe to DataMemory.
- RAM_MemRead  out  1  gated load strobe to DataMemory.
- ReadData  out  32  load data to MEM/WB.
- PortOut  out  32  output port register.
- Irq  out  1  interrupt request.

Behaviour:
- Decode: is_io = (Address[31:5] == IO_BASE[31:5]); offset = Address[4:2]; Address[1:0] ignored inside the window.
- RAM gating: RAM_MemWrite = MemWrite & ~is_io; RAM_MemRead = MemRead & ~is_io.
- Read data: ReadData = is_io ? io_rdata : RAMReadData. Combinational from registered state, so loads add no cycle.
- Register map (word offsets):
  - 0 PORT_OUT (RW).
  - 1 PORT_IN (RO): zero-extended synchronized input.
  - 2 STATUS (RW1C): bit0 in_changed, bit1 timer_match; bits 31:2 read 0.
  - 3 TIMER_CMP (RW).
  - 4 TIMER_CNT (RO; any write clears it to 0).
  - 5 IRQ_EN (RW, bits 1:0).
  - 6 and 7 read 0; writes ignored.
- Writes: take effect at the clock edge where MemWrite & is_io; all 32 bits are written.
- Input synchronizer: PortIn -> s1 -> s2 (two flops); prev <= s2 each cycle.
  - in_changed is set at the edge where s2 != prev.
  - A PortIn change before edge k reads back in PORT_IN after edge k+1 and sets in_changed at edge k+2.
- Timer:
  - TIMER_CMP == 0: counter disabled, CNT held at 0.
  - Otherwise, each cycle: if CNT == CMP then CNT <= 0 and timer_match <= 1, else CNT <= CNT+1. Period is CMP+1 cycles.
  - Writing TIMER_CMP also clears CNT in the same edge.
- STATUS W1C: writing 1 to a bit clears it. If a hardware set and a W1C land on the same edge, set wins (the flag stays 1).
- Irq = |(STATUS[1:0] & IRQ_EN[1:0]), combinational from registers.
- Reset:
  - PORT_OUT, STATUS, TIMER_CMP, TIMER_CNT, IRQ_EN, s1, s2 and prev all clear to 0.
  - Outputs after reset: PortOut = 0, Irq = 0; ReadData and the RAM strobes follow their inputs.
  - A nonzero PortIn held through reset sets in_changed 2 edges after reset deasserts.
  - Reset asserted mid-count aborts the count and the pending flag; reset wins over a simultaneous write.
- Simultaneous MemRead and MemWrite to the same I/O register: read returns the pre-write value.
- Accesses outside the window never alter I/O state.

Test Plan:
- Reset, then store 0xDEADBEEF to IO_BASE+0x00 -> PortOut = 0xDEADBEEF after that edge; RAM_MemWrite = 0 in that cycle; store to 0x1001_0040 -> RAM_MemWrite = 1, PortOut unchanged.
- PortIn 0x00 -> 0x5A before edge k -> load of IO_BASE+0x04 returns 0x0000005A from edge k+1; STATUS = 0x1 from edge k+2; W1C 0x1 -> STATUS = 0.
- TIMER_CMP = 3, IRQ_EN = 0x2 -> CNT reads 0,1,2,3,0; timer_match and Irq rise on the wrap edge (4 cycles after the write); W1C 0x2 -> Irq = 0; next match 4 cycles later.
- W1C of bit1 issued on the exact edge the timer matches -> STATUS bit1 remains 1.
- Load of IO_BASE+0x18 -> 0; load of 0x1000_0000 -> ReadData = RAMReadData with RAM_MemRead = 1.
- Assert reset for 1 cycle with TIMER_CNT = 2 and PortOut = 0xFF -> all registers 0, Irq = 0, counter disabled until TIMER_CMP is rewritten.

Source files
------------

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: memory-stage address decoder between EX/MEM and DataMemory.
// Loads and stores that fall in a 32-byte I/O window are steered to on-block
// registers instead of RAM: an output port, a synchronized input port with
// change detect, an interval timer and a maskable interrupt line.
//
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   Address        - byte address from the EX/MEM ALU result
//   WriteData      - store data from EX/MEM
//   MemWrite       - store strobe from EX/MEM
//   MemRead        - load strobe from EX/MEM
//   RAMReadData    - DataMemory read data
//   PortIn         - asynchronous external input
//   RAM_MemWrite   - store strobe to DataMemory, suppressed inside the window
//   RAM_MemRead    - load strobe to DataMemory, suppressed inside the window
//   ReadData       - load data to MEM/WB (I/O register or RAM data)
//   PortOut        - software-driven output port register
//   Irq            - interrupt request
//
// Register map (word offsets): 0 PORT_OUT, 1 PORT_IN, 2 STATUS (W1C),
// 3 TIMER_CMP, 4 TIMER_CNT, 5 IRQ_EN, 6/7 reserved (read 0).
module mem_io_bridge #(
  parameter logic [31:0] IO_BASE  = 32'h1001_0000,
  parameter int          IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [31:0]         RAMReadData,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic                RAM_MemWrite,
  output logic                RAM_MemRead,
  output logic [31:0]         ReadData,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
  localparam logic [2:0] OFF_PORT_IN   = 3'd1;
  localparam logic [2:0] OFF_STATUS    = 3'd2;
  localparam logic [2:0] OFF_TIMER_CMP = 3'd3;
  localparam logic [2:0] OFF_TIMER_CNT = 3'd4;
  localparam logic [2:0] OFF_IRQ_EN    = 3'd5;

  logic                is_io_s;
  logic [2:0]          offset_s;
  logic                io_wr_s;
  logic                wr_status_s;
  logic                in_change_s;
  logic                timer_hit_s;
  logic [31:0]         io_rdata_s;
  logic                unused_addr_lsb_s;

  logic [31:0]         port_out_r;
  logic [IN_WIDTH-1:0] s1_r;
  logic [IN_WIDTH-1:0] s2_r;
  logic [IN_WIDTH-1:0] prev_r;
  logic                in_changed_r;
  logic                timer_match_r;
  logic [31:0]         timer_cmp_r;
  logic [31:0]         timer_cnt_r;
  logic [1:0]          irq_en_r;

  // Byte lanes are ignored inside the window; every access is a full word.
  assign unused_addr_lsb_s = ^Address[1:0];

  assign is_io_s      = (Address[31:5] == IO_BASE[31:5]);
  assign offset_s     = Address[4:2];
  assign io_wr_s      = MemWrite & is_io_s;
  assign wr_status_s  = io_wr_s & (offset_s == OFF_STATUS);
  assign in_change_s  = (s2_r != prev_r);
  // A zero compare value disables the timer, so no match is ever raised then.
  assign timer_hit_s  = (timer_cmp_r != 32'd0) && (timer_cnt_r == timer_cmp_r);

  assign RAM_MemWrite = MemWrite & ~is_io_s;
  assign RAM_MemRead  = MemRead & ~is_io_s;
  assign ReadData     = is_io_s ? io_rdata_s : RAMReadData;
  assign PortOut      = port_out_r;
  assign Irq          = |({timer_match_r, in_changed_r} & irq_en_r);

  // I/O register read mux; reads see the pre-write value of the same cycle.
  always_comb begin
    io_rdata_s = 32'd0;
    case (offset_s)
      OFF_PORT_OUT:  io_rdata_s = port_out_r;
      OFF_PORT_IN:   io_rdata_s = 32'(s2_r);
      OFF_STATUS:    io_rdata_s = {30'd0, timer_match_r, in_changed_r};
      OFF_TIMER_CMP: io_rdata_s = timer_cmp_r;
      OFF_TIMER_CNT: io_rdata_s = timer_cnt_r;
      OFF_IRQ_EN:    io_rdata_s = {30'd0, irq_en_r};
      default:       io_rdata_s = 32'd0;
    endcase
  end

  // All I/O state: synchronizer, port/irq-enable registers, flags and timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r          <= '0;
      s2_r          <= '0;
      prev_r        <= '0;
      port_out_r    <= 32'd0;
      irq_en_r      <= 2'd0;
      in_changed_r  <= 1'b0;
      timer_match_r <= 1'b0;
      timer_cmp_r   <= 32'd0;
      timer_cnt_r   <= 32'd0;
    end else begin
      s1_r   <= PortIn;
      s2_r   <= s1_r;
      prev_r <= s2_r;

      if (io_wr_s && (offset_s == OFF_PORT_OUT)) begin
        port_out_r <= WriteData;
      end else begin
        port_out_r <= port_out_r;
      end

      if (io_wr_s && (offset_s == OFF_IRQ_EN)) begin
        irq_en_r <= WriteData[1:0];
      end else begin
        irq_en_r <= irq_en_r;
      end

      // Hardware set beats a write-one-to-clear landing on the same edge.
      in_changed_r  <= in_change_s | (in_changed_r & ~(wr_status_s & WriteData[0]));
      timer_match_r <= timer_hit_s | (timer_match_r & ~(wr_status_s & WriteData[1]));

      // Writing the compare value or the counter restarts the count from 0.
      if (io_wr_s && (offset_s == OFF_TIMER_CMP)) begin
        timer_cmp_r <= WriteData;
        timer_cnt_r <= 32'd0;
      end else if ((io_wr_s && (offset_s == OFF_TIMER_CNT)) ||
                   (timer_cmp_r == 32'd0) || timer_hit_s) begin
        timer_cmp_r <= timer_cmp_r;
        timer_cnt_r <= 32'd0;
      end else begin
        timer_cmp_r <= timer_cmp_r;
        timer_cnt_r <= timer_cnt_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: a driver issues accesses and pushes the
// expected response of every access cycle into a queue; a monitor on the
// falling edge pops and compares whenever the DUT sees a load or store.
module tb_mem_io_bridge;

  localparam logic [31:0] IO = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, RAMReadData;
  logic        MemWrite, MemRead;
  logic [7:0]  PortIn;
  logic        RAM_MemWrite, RAM_MemRead, Irq;
  logic [31:0] ReadData, PortOut;

  mem_io_bridge #(.IO_BASE(IO), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .RAMReadData(RAMReadData),
    .PortIn(PortIn), .RAM_MemWrite(RAM_MemWrite), .RAM_MemRead(RAM_MemRead),
    .ReadData(ReadData), .PortOut(PortOut), .Irq(Irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        re;
    logic        chk_c;
    logic [31:0] rdata;
    logic [31:0] cval;
    logic [31:0] pout;
    logic        ram_rd;
    logic        ram_wr;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;

  // ---------------- behavioural reference model ----------------
  // State after edge m_n. The synchronizer is modelled as a history of the
  // PortIn value sampled at each edge; the timer as elapsed edges since the
  // last restart, taken modulo the period.
  logic [31:0] m_port_out, m_cmp;
  logic [1:0]  m_irq_en;
  logic        m_chg, m_match;
  longint      m_n, m_tstart;
  logic [7:0]  hist [0:4095];

  function automatic logic [31:0] m_cnt();
    if (m_cmp == 32'd0) return 32'd0;
    return 32'((m_n - m_tstart) % (longint'(m_cmp) + 64'sd1));
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0: return m_port_out;
      3'd1: return {24'd0, hist[m_n - 1]};
      3'd2: return {30'd0, m_match, m_chg};
      3'd3: return m_cmp;
      3'd4: return m_cnt();
      3'd5: return {30'd0, m_irq_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                            input logic we, input logic [7:0] pin);
    logic hw_chg, hw_match, w;
    logic [2:0] off;
    if (rst) begin
      m_port_out = 32'd0; m_cmp = 32'd0; m_irq_en = 2'd0;
      m_chg = 1'b0; m_match = 1'b0; m_tstart = m_n + 1;
      hist[m_n + 1] = 8'd0; hist[m_n] = 8'd0; hist[m_n - 1] = 8'd0;
    end else begin
      hw_chg   = (hist[m_n - 1] != hist[m_n - 2]);
      hw_match = (m_cmp != 32'd0) && (m_cnt() == m_cmp);
      hist[m_n + 1] = pin;
      w   = we && (a[31:5] == IO[31:5]);
      off = a[4:2];
      m_chg   = hw_chg   | (m_chg   & !(w && off == 3'd2 && wd[0]));
      m_match = hw_match | (m_match & !(w && off == 3'd2 && wd[1]));
      if (w) begin
        case (off)
          3'd0: m_port_out = wd;
          3'd3: begin m_cmp = wd; m_tstart = m_n + 1; end
          3'd4: m_tstart = m_n + 1;
          3'd5: m_irq_en = wd[1:0];
          default: ;
        endcase
      end
    end
    m_n = m_n + 1;
  endtask

  // ---------------- driver ----------------
  logic [7:0] pin_v = 8'd0;

  // One clock cycle of stimulus, entered and left 1 time unit after a rising edge.
  task automatic cyc(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                     input logic we, input logic re, input logic chk_c, input logic [31:0] cval);
    exp_t e;
    logic io;
    reset = rst; Address = a; WriteData = wd; MemWrite = we; MemRead = re;
    RAMReadData = $urandom; PortIn = pin_v;
    if (we || re) begin
      io = (a[31:5] == IO[31:5]);
      e.id = txn_id; e.re = re; e.chk_c = chk_c; e.cval = cval;
      e.rdata  = io ? m_read(a[4:2]) : RAMReadData;
      e.pout   = m_port_out;
      e.ram_rd = re & !io;
      e.ram_wr = we & !io;
      e.irq    = |({m_match, m_chg} & m_irq_en);
      q.push_back(e);
    end
    txn_id++;
    @(posedge clk);
    model_edge(rst, a, wd, we, pin_v);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, a, d, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] c);
    cyc(1'b0, a, 32'd0, 1'b0, 1'b1, 1'b1, c);
  endtask
  task automatic rdm(input logic [31:0] a);
    cyc(1'b0, a, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
  endtask
  task automatic idle();
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h expected=%h", nm, id, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (MemRead === 1'b1 || MemWrite === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty got=access expected=entry");
      end else begin
        e = q.pop_front();
        chk("ram_memwrite", e.id, {31'd0, RAM_MemWrite}, {31'd0, e.ram_wr});
        chk("ram_memread",  e.id, {31'd0, RAM_MemRead},  {31'd0, e.ram_rd});
        chk("portout",      e.id, PortOut, e.pout);
        chk("irq",          e.id, {31'd0, Irq}, {31'd0, e.irq});
        if (e.re) chk("readdata", e.id, ReadData, e.rdata);
        if (e.chk_c) chk("readdata_const", e.id, ReadData, e.cval);
      end
    end
  end

  // Absolute bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d;
    logic we, re, rs;
    m_port_out = 32'd0; m_cmp = 32'd0; m_irq_en = 2'd0;
    m_chg = 1'b0; m_match = 1'b0; m_n = 3; m_tstart = 3;
    for (int i = 0; i < 4096; i++) hist[i] = 8'd0;

    cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Reset state
    rd(IO + 32'h00, 32'd0);
    rd(IO + 32'h08, 32'd0);
    rd(IO + 32'h10, 32'd0);

    // Output port and RAM steering
    wr(IO + 32'h00, 32'hDEAD_BEEF);
    rd(IO + 32'h00, 32'hDEAD_BEEF);
    wr(32'h1001_0040, 32'h1234_5678);
    rd(IO + 32'h03, 32'hDEAD_BEEF);

    // Input synchronizer and change flag
    pin_v = 8'h5A;
    idle();                       // PortIn changes before edge k
    rd(IO + 32'h04, 32'd0);       // after k
    rd(IO + 32'h04, 32'h0000_005A); // after k+1
    rd(IO + 32'h08, 32'h0000_0001); // after k+2
    wr(IO + 32'h08, 32'h0000_0001);
    rd(IO + 32'h08, 32'd0);

    // Timer, irq, W1C and set-beats-clear
    wr(IO + 32'h14, 32'd2);
    wr(IO + 32'h0C, 32'd3);       // edge w
    rd(IO + 32'h10, 32'd0);
    rd(IO + 32'h10, 32'd1);
    rd(IO + 32'h10, 32'd2);
    rd(IO + 32'h10, 32'd3);
    rd(IO + 32'h08, 32'd2);       // after w+4: match set
    wr(IO + 32'h08, 32'd2);       // clears at w+6
    rd(IO + 32'h08, 32'd0);
    wr(IO + 32'h08, 32'd2);       // lands on match edge w+8
    rd(IO + 32'h08, 32'd2);
    rd(IO + 32'h10, 32'd1);
    wr(IO + 32'h08, 32'd2);

    // Reserved offsets and RAM pass-through
    wr(IO + 32'h18, 32'hFFFF_FFFF);
    rd(IO + 32'h18, 32'd0);
    rd(IO + 32'h1C, 32'd0);
    rdm(32'h1000_0000);
    rdm(IO - 32'd4);

    // Reset mid-count with a simultaneous write
    wr(IO + 32'h00, 32'h0000_00FF);
    wr(IO + 32'h0C, 32'd5);
    idle();
    idle();                        // CNT = 2 now
    cyc(1'b1, IO + 32'h00, 32'h55, 1'b1, 1'b0, 1'b0, 32'd0);
    rd(IO + 32'h00, 32'd0);
    rd(IO + 32'h10, 32'd0);
    rd(IO + 32'h08, 32'd0);
    rd(IO + 32'h08, 32'd1);        // held PortIn flags change after reset
    rd(IO + 32'h10, 32'd0);
    rd(IO + 32'h0C, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) pin_v = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       a = IO - 32'd4;
        1:       a = IO + 32'd32;
        2:       a = 32'h1000_0000 + ($urandom_range(0, 1023) << 2);
        default: a = IO + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      endcase
      d  = (a[4:2] == 3'd3) ? 32'($urandom_range(0, 6)) : $urandom;
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 0);
      rs = ($urandom_range(0, 99) == 0);
      cyc(rs, a, d, we, re, 1'b0, 32'd0);
    end
    idle();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
